// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field layout and exponent bias.
// Imported by the integer-to-float converter and its leading-zero counter.
package fpu_pkg;

    localparam int FLOAT_BIAS = 127;
    localparam int INT_MSB    = 31;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; result is 0 for a zero input
// (callers treat the zero case separately).
module lzc32 (
    input  logic [31:0] a,
    output logic [4:0]  lz
);

    // Ascending scan: the highest set bit is the last one to write lz.
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) lz = 5'(31 - i);
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 to binary32 converter (round to nearest even)
// behind a valid/ready handshake with a single global advance.
import fpu_pkg::*;

module itof_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z
);

    localparam logic [7:0] EXP_TOP = 8'(FLOAT_BIAS + INT_MSB);

    logic        adv;

    logic        s1_v;
    logic        s1_s;
    logic [31:0] s1_a;

    logic        s2_v;
    logic        s2_s;
    logic [31:0] s2_n;
    logic [7:0]  s2_e;

    logic        s3_v;
    float_t      s3_z;

    logic [31:0] mag;
    logic [4:0]  lz;

    logic [22:0] m;
    logic        g;
    logic        st;
    logic        rup;
    logic [23:0] m_sum;
    logic [7:0]  e_rnd;
    float_t      z_next;

    assign adv       = ~s3_v | out_ready;
    assign in_ready  = adv;
    assign out_valid = s3_v;
    assign z         = s3_z;

    // -(-2^31) wraps back to 0x80000000, which is the correct magnitude.
    assign mag = x[31] ? (~x + 32'd1) : x;

    lzc32 u_lzc (
        .a  (s1_a),
        .lz (lz)
    );

    // A nonzero magnitude always normalizes with n[31] set, so the MSB of
    // the normalized value doubles as the nonzero flag.
    always_comb begin
        m      = s2_n[30:8];
        g      = s2_n[7];
        st     = |s2_n[6:0];
        rup    = g & (st | m[0]);
        m_sum  = {1'b0, m} + {23'd0, rup};
        e_rnd  = s2_e + {7'd0, m_sum[23]};
        z_next = '0;
        if (s2_n[31]) begin
            z_next.sign = s2_s;
            z_next.exp  = e_rnd;
            z_next.man  = m_sum[22:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_s <= 1'b0;
            s1_a <= '0;
            s2_v <= 1'b0;
            s2_s <= 1'b0;
            s2_n <= '0;
            s2_e <= '0;
            s3_v <= 1'b0;
            s3_z <= '0;
        end else if (adv) begin
            s1_v <= in_valid;
            s1_s <= x[31];
            s1_a <= mag;
            s2_v <= s1_v;
            s2_s <= s1_s;
            s2_n <= s1_a << lz;
            s2_e <= EXP_TOP - {3'd0, lz};
            s3_v <= s2_v;
            s3_z <= z_next;
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed vectors, backpressure,
// mid-stream reset and randomized traffic against an arithmetic model.
module tb_itof_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;

    int n_cmp;
    int n_bad;

    logic [31:0] stim[$];
    logic [31:0] expv[$];
    logic        cap_v[$];
    logic [31:0] cap_z[$];

    itof_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer -> binary32 via exact integer arithmetic: quotient/remainder
    // against the half-ulp, ties to even.
    function automatic logic [31:0] ref_itof(input logic [31:0] xv);
        int     xi;
        longint v, a, q, r, half;
        int     p, sh;
        logic   sgn;
        xi = xv;
        v  = longint'(xi);
        if (v == 0) return 32'h0;
        sgn = (v < 0);
        a   = sgn ? -v : v;
        p   = 0;
        for (int i = 0; i < 32; i++)
            if (a >= (longint'(1) << i)) p = i;
        if (p <= 23) begin
            q = a << (23 - p);
        end else begin
            sh   = p - 23;
            q    = a >> sh;
            r    = a - (q << sh);
            half = longint'(1) << (sh - 1);
            if (r > half || (r == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        return {sgn, 8'(p + 127), q[22:0]};
    endfunction

    // Drive stim back-to-back with out_ready=1, capturing outputs each cycle.
    task automatic run_stream();
        int n;
        n = stim.size();
        cap_v.delete();
        cap_z.delete();
        out_ready = 1'b1;
        for (int c = 0; c < n + 4; c++) begin
            #1;
            cap_v.push_back(out_valid);
            cap_z.push_back(z);
            in_valid = (c < n);
            if (c < n) x = stim[c];
            else       x = 32'h0;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++;
        if (z !== 32'h0) begin n_bad++; $display("FAIL reset_z got %h want 00000000", z); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        stim = '{32'd1, 32'hFFFFFFFF, 32'd3, 32'd0};
        expv = '{32'h3F800000, 32'hBF800000, 32'h40400000, 32'h00000000};
        n = stim.size();
        run_stream();
        for (int c = 0; c < cap_v.size(); c++) begin
            logic ev;
            ev = (c >= 3 && c < n + 3);
            n_cmp++;
            if (cap_v[c] !== ev) begin n_bad++; $display("FAIL basic_valid cyc=%0d got %b want %b", c, cap_v[c], ev); end
            if (ev) begin
                n_cmp++;
                if (cap_z[c] !== expv[c-3]) begin n_bad++; $display("FAIL basic_z x=%h got %h want %h", stim[c-3], cap_z[c], expv[c-3]); end
            end
        end
    endtask

    task automatic test_extremes();
        int n;
        stim = '{32'h80000000, 32'h7FFFFFFF, 32'd16777216};
        expv = '{32'hCF000000, 32'h4F000000, 32'h4B800000};
        n = stim.size();
        run_stream();
        for (int c = 0; c < cap_v.size(); c++) begin
            logic ev;
            ev = (c >= 3 && c < n + 3);
            n_cmp++;
            if (cap_v[c] !== ev) begin n_bad++; $display("FAIL extreme_valid cyc=%0d got %b want %b", c, cap_v[c], ev); end
            if (ev) begin
                n_cmp++;
                if (cap_z[c] !== expv[c-3]) begin n_bad++; $display("FAIL extreme_z x=%h got %h want %h", stim[c-3], cap_z[c], expv[c-3]); end
            end
        end
    endtask

    task automatic test_ties();
        int n;
        stim = '{32'd16777217, 32'd16777219, 32'd16777218};
        expv = '{32'h4B800000, 32'h4B800002, 32'h4B800001};
        n = stim.size();
        run_stream();
        for (int c = 0; c < cap_v.size(); c++) begin
            logic ev;
            ev = (c >= 3 && c < n + 3);
            n_cmp++;
            if (cap_v[c] !== ev) begin n_bad++; $display("FAIL tie_valid cyc=%0d got %b want %b", c, cap_v[c], ev); end
            if (ev) begin
                n_cmp++;
                if (cap_z[c] !== expv[c-3]) begin n_bad++; $display("FAIL tie_z x=%h got %h want %h", stim[c-3], cap_z[c], expv[c-3]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] q_exp[$];
        logic [31:0] ops[5];
        logic [31:0] held;
        logic [31:0] want;
        logic        was_stall;
        int          sent, got, stalls;
        sent = 0; got = 0; stalls = 0; was_stall = 1'b0; held = '0;
        for (int i = 0; i < 5; i++) ops[i] = $urandom();
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 4 && c <= 7);
            in_valid  = (sent < 5);
            x         = (sent < 5) ? ops[sent] : 32'h0;
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                n_cmp++;
                if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc=%0d got %b want 0", c, in_ready); end
                if (was_stall) begin
                    n_cmp++;
                    if (z !== held) begin n_bad++; $display("FAIL bp_stall_z cyc=%0d got %h want %h", c, z, held); end
                end
                held      = z;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                got++;
                n_cmp++;
                if (q_exp.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra got %h want none", z);
                end else begin
                    want = q_exp.pop_front();
                    if (z !== want) begin n_bad++; $display("FAIL bp_z cyc=%0d got %h want %h", c, z, want); end
                end
            end
            if (in_valid && in_ready) begin
                q_exp.push_back(ref_itof(x));
                sent++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got != 5) begin n_bad++; $display("FAIL bp_count got %0d want 5", got); end
        n_cmp++;
        if (stalls != 4) begin n_bad++; $display("FAIL bp_stall_cycles got %0d want 4", stalls); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            x        = $urandom() | 32'h1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_out_valid got %b want 0", out_valid); end
        n_cmp++;
        if (z !== 32'h0) begin n_bad++; $display("FAIL mrst_z got %h want 00000000", z); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_stale cyc=%0d got out_valid=%b z=%h want 0", c, out_valid, z); end
        end
    endtask

    task automatic test_random();
        localparam int N_RAND = 4000;
        logic [31:0] q_exp[$];
        logic [31:0] held;
        logic [31:0] want;
        logic [31:0] v;
        logic        was_stall;
        int          sent, got, cyc;
        sent = 0; got = 0; cyc = 0; was_stall = 1'b0; held = '0;
        while (got < N_RAND && cyc < 30000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: v = $urandom();
                1: v = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: begin
                    v = (32'd1 << $urandom_range(23, 30)) + 32'($urandom_range(0, 7)) - 32'd3;
                    if ($urandom_range(0, 1) != 0) v = -v;
                end
                default: begin
                    case ($urandom_range(0, 4))
                        0: v = 32'h0;
                        1: v = 32'h1;
                        2: v = 32'hFFFFFFFF;
                        3: v = 32'h80000000;
                        default: v = 32'h7FFFFFFF;
                    endcase
                end
            endcase
            x = v;
            #1;
            n_cmp++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_bad++; $display("FAIL rnd_in_ready cyc=%0d got %b want %b", cyc, in_ready, (!out_valid || out_ready));
            end
            if (was_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || z !== held) begin
                    n_bad++; $display("FAIL rnd_stall cyc=%0d got v=%b z=%h want v=1 z=%h", cyc, out_valid, z, held);
                end
            end
            was_stall = out_valid && !out_ready;
            held      = z;
            if (out_valid && out_ready) begin
                got++;
                n_cmp++;
                if (q_exp.size() == 0) begin
                    n_bad++; $display("FAIL rnd_extra cyc=%0d got %h want none", cyc, z);
                end else begin
                    want = q_exp.pop_front();
                    if (z !== want) begin n_bad++; $display("FAIL rnd_z cyc=%0d got %h want %h", cyc, z, want); end
                end
            end
            if (in_valid && in_ready) begin
                q_exp.push_back(ref_itof(x));
                sent++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got != N_RAND) begin n_bad++; $display("FAIL rnd_count got %0d want %0d", got, N_RAND); end
        n_cmp++;
        if (q_exp.size() != 0) begin n_bad++; $display("FAIL rnd_leftover got %0d want 0", q_exp.size()); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_basic();
        test_extremes();
        test_ties();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
